// File: rtl/mandel_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mandel_pkg
// Brief   : shared widths, scan FSM states and latched configuration record
// Rev     : 1.0
// ============================================================================
package mandel_pkg;

  localparam int C_COORD_W   = 32;
  localparam int C_DIM_W     = 16;
  localparam int C_ITER_W    = 16;
  localparam int C_FRAC_BITS = 28;  // Q4.28 coordinate format

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ROW_WAIT  = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_RSP  = 3'd3,
    ST_EMIT      = 3'd4,
    ST_FRAME_GAP = 3'd5,
    ST_CLEAR     = 3'd6
  } scan_state_t;

  typedef struct packed {
    logic [C_DIM_W-1:0]   width;
    logic [C_DIM_W-1:0]   height;
    logic [C_COORD_W-1:0] xstart;
    logic [C_COORD_W-1:0] ystart;
    logic [C_COORD_W-1:0] xincr;
    logic [C_COORD_W-1:0] yincr;
    logic [7:0]           frames;
  } scan_cfg_t;

endpackage
`default_nettype wire

// File: rtl/mandel_coord_gen.sv
`default_nettype none
// ============================================================================
// Module  : mandel_coord_gen
// Brief   : real/imag coordinate accumulators, wrapping two's-complement adds
// Rev     : 1.0
// ============================================================================
module mandel_coord_gen
  import mandel_pkg::*;
#(
  parameter int COORD_W = C_COORD_W
) (
  input  logic               sync_clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic               load_row,
  input  logic               step_x,
  input  logic               step_y,
  input  logic [COORD_W-1:0] xstart,
  input  logic [COORD_W-1:0] ystart,
  input  logic [COORD_W-1:0] xincr,
  input  logic [COORD_W-1:0] yincr,
  output logic [COORD_W-1:0] xr,
  output logic [COORD_W-1:0] yr
);

  logic [COORD_W-1:0] r_xr;
  logic [COORD_W-1:0] r_yr;

  always_ff @(posedge sync_clk) begin
    if (rst) begin
      r_xr <= '0;
      r_yr <= '0;
    end else if (load_start) begin
      r_xr <= xstart;
      r_yr <= ystart;
    end else begin
      if (load_row) begin
        r_xr <= xstart;
      end else if (step_x) begin
        r_xr <= r_xr + xincr;
      end
      if (step_y) begin
        r_yr <= r_yr + yincr;
      end
    end
  end

  assign xr = r_xr;
  assign yr = r_yr;

endmodule
`default_nettype wire

// File: rtl/mandel_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mandel_scan_ctrl
// Brief   : scans a pixel window, drives an iteration engine, streams pixels
// Rev     : 1.0
// ============================================================================
module mandel_scan_ctrl
  import mandel_pkg::*;
#(
  parameter int COORD_W     = C_COORD_W,
  parameter int DIM_W       = C_DIM_W,
  parameter int ITER_W      = C_ITER_W,
  parameter int MAX_ITER    = 1000,
  parameter int FLUSH_EVERY = 10,
  parameter int LINE_GAP    = 10,
  parameter int FRAME_GAP   = 200
) (
  input  logic               sync_clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DIM_W-1:0]   cfg_width,
  input  logic [DIM_W-1:0]   cfg_height,
  input  logic [COORD_W-1:0] cfg_xstart,
  input  logic [COORD_W-1:0] cfg_ystart,
  input  logic [COORD_W-1:0] cfg_xincr,
  input  logic [COORD_W-1:0] cfg_yincr,
  input  logic [7:0]         cfg_frames,
  output logic               eng_req_valid,
  input  logic               eng_req_ready,
  output logic [COORD_W-1:0] eng_c_re,
  output logic [COORD_W-1:0] eng_c_im,
  input  logic               eng_rsp_valid,
  input  logic [ITER_W-1:0]  eng_rsp_iter,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [DIM_W-1:0]   pix_x,
  output logic [DIM_W-1:0]   pix_y,
  output logic [ITER_W-1:0]  pix_n,
  output logic               flush,
  output logic               frame_done,
  output logic               clear,
  output logic               busy
);

  localparam int GAP_MAX = (LINE_GAP > FRAME_GAP) ? LINE_GAP : FRAME_GAP;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);
  localparam int FC_W    = (FLUSH_EVERY > 1) ? $clog2(FLUSH_EVERY) : 1;

  scan_state_t       r_state;
  scan_state_t       w_next;
  scan_cfg_t         r_cfg;
  scan_cfg_t         w_cfg_in;
  scan_cfg_t         w_cfg_src;
  logic [DIM_W-1:0]  r_x;
  logic [DIM_W-1:0]  r_y;
  logic [ITER_W-1:0] r_n;
  logic [7:0]        r_frame;
  logic [GAP_W-1:0]  r_gap;
  logic [FC_W-1:0]   r_fcnt;
  logic              w_load_start;
  logic              w_load_row;
  logic              w_step_x;
  logic              w_step_y;
  logic              w_last_x;
  logic              w_last_y;
  logic              w_cfg_ok;

  assign w_cfg_in = '{width:  cfg_width,  height: cfg_height,
                      xstart: cfg_xstart, ystart: cfg_ystart,
                      xincr:  cfg_xincr,  yincr:  cfg_yincr,
                      frames: cfg_frames};

  // In IDLE the accumulators load straight from the request, before it is latched
  assign w_cfg_src = (r_state == ST_IDLE) ? w_cfg_in : r_cfg;

  assign w_cfg_ok = (cfg_width != '0) && (cfg_height != '0) && (cfg_frames != 8'd0);
  assign w_last_x = (r_x == r_cfg.width - DIM_W'(1));
  assign w_last_y = (r_y == r_cfg.height - DIM_W'(1));

  always_comb begin
    w_next        = r_state;
    w_load_start  = 1'b0;
    w_load_row    = 1'b0;
    w_step_x      = 1'b0;
    w_step_y      = 1'b0;
    eng_req_valid = 1'b0;
    pix_valid     = 1'b0;
    flush         = 1'b0;
    frame_done    = 1'b0;
    clear         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_valid && w_cfg_ok) begin
          w_load_start = 1'b1;
          w_next       = ST_ROW_WAIT;
        end
      end
      ST_ROW_WAIT: begin
        if (r_gap == GAP_W'(LINE_GAP - 1)) begin
          w_load_row = 1'b1;
          w_next     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        eng_req_valid = 1'b1;
        if (eng_req_ready) w_next = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (eng_rsp_valid) w_next = ST_EMIT;
      end
      ST_EMIT: begin
        pix_valid = 1'b1;
        if (pix_ready) begin
          flush    = (r_fcnt == '0);
          w_step_x = 1'b1;
          if (w_last_x) begin
            w_step_y = 1'b1;
            if (w_last_y) begin
              frame_done = 1'b1;
              w_next     = ST_FRAME_GAP;
            end else begin
              w_next = ST_ROW_WAIT;
            end
          end else begin
            w_next = ST_ISSUE;
          end
        end
      end
      ST_FRAME_GAP: begin
        if (r_gap == GAP_W'(FRAME_GAP - 1)) w_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        clear = 1'b1;
        if (r_frame + 8'd1 == r_cfg.frames) begin
          w_next = ST_IDLE;
        end else begin
          w_load_start = 1'b1;
          w_next       = ST_ROW_WAIT;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sync_clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cfg   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_n     <= '0;
      r_frame <= '0;
      r_gap   <= '0;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_next;

      if (r_state == ST_IDLE && w_load_start) begin
        r_cfg   <= w_cfg_in;
        r_frame <= '0;
      end else if (r_state == ST_CLEAR) begin
        r_frame <= r_frame + 8'd1;
      end

      // Gap timer runs only while parked in a gap state and restarts on any exit
      if ((r_state == ST_ROW_WAIT || r_state == ST_FRAME_GAP) && w_next == r_state) begin
        r_gap <= r_gap + GAP_W'(1);
      end else begin
        r_gap <= '0;
      end

      if (r_state == ST_WAIT_RSP && eng_rsp_valid) begin
        r_n <= (eng_rsp_iter == ITER_W'(MAX_ITER)) ? '0 : eng_rsp_iter;
      end

      if (w_load_start) begin
        r_x    <= '0;
        r_y    <= '0;
        r_fcnt <= '0;
      end else if (w_step_x) begin
        if (w_last_x) begin
          r_x    <= '0;
          r_fcnt <= '0;
        end else begin
          r_x    <= r_x + DIM_W'(1);
          r_fcnt <= (r_fcnt == FC_W'(FLUSH_EVERY - 1)) ? '0 : r_fcnt + FC_W'(1);
        end
        if (w_step_y) r_y <= r_y + DIM_W'(1);
      end
    end
  end

  mandel_coord_gen #(
    .COORD_W (COORD_W)
  ) u_coord_gen (
    .sync_clk   (sync_clk),
    .rst        (rst),
    .load_start (w_load_start),
    .load_row   (w_load_row),
    .step_x     (w_step_x),
    .step_y     (w_step_y),
    .xstart     (w_cfg_src.xstart),
    .ystart     (w_cfg_src.ystart),
    .xincr      (w_cfg_src.xincr),
    .yincr      (w_cfg_src.yincr),
    .xr         (eng_c_re),
    .yr         (eng_c_im)
  );

  assign cfg_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign pix_x     = r_x;
  assign pix_y     = r_y;
  assign pix_n     = r_n;

endmodule
`default_nettype wire
